// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues word fetches, applies branch redirects
// and gives the bus to DMA via HOLD/HLDA at instruction boundaries. Optional perf counters: FETCH_PERF_CNT_EN.
module if_fetch_unit #(
    parameter int unsigned ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_rdata,
    input  logic              imem_ready,
    input  logic              hold,
    output logic              hlda,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    output logic [31:0]       inst_out,
    output logic [ADDR_W-1:0] pc_out,
    output logic              flush,
    output logic              valid,
    output logic [31:0]       perf_fetch_cnt,
    output logic [31:0]       perf_hold_cnt
);

    localparam int unsigned INST_W = 32;
    localparam int unsigned CNT_W  = 32;
    localparam logic [ADDR_W-1:0] PC_STEP    = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

    typedef enum logic {
        S_FETCH = 1'b0,
        S_HOLD  = 1'b1
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [ADDR_W-1:0]   pc;
    logic [ADDR_W-1:0]   pc_next;
    logic [INST_W-1:0]   inst_next;
    logic [ADDR_W-1:0]   pc_out_next;
    logic                valid_next;
    logic                flush_next;
    logic                hlda_next;
    logic                fetch_done;
    logic                at_boundary;

    // Bus side is combinational from state/stall so a stall suppresses the request the same cycle
    assign imem_req    = (state == S_FETCH) && !stall && !rst;
    assign imem_addr   = pc;
    assign fetch_done  = imem_req && imem_ready;
    assign at_boundary = fetch_done || !imem_req;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_FETCH;
            pc       <= RESET_PC;
            inst_out <= '0;
            pc_out   <= '0;
            valid    <= 1'b0;
            flush    <= 1'b0;
            hlda     <= 1'b0;
        end else begin
            state    <= state_next;
            pc       <= pc_next;
            inst_out <= inst_next;
            pc_out   <= pc_out_next;
            valid    <= valid_next;
            flush    <= flush_next;
            hlda     <= hlda_next;
        end
    end

    // Redirect wins over a fetch completing in the same cycle; the hold handshake runs independently
    always_comb begin
        state_next  = state;
        pc_next     = pc;
        inst_next   = inst_out;
        pc_out_next = pc_out;
        valid_next  = 1'b0;
        flush_next  = 1'b0;
        hlda_next   = hlda;

        if (branch_taken) begin
            pc_next    = branch_target & ALIGN_MASK;
            flush_next = 1'b1;
        end else if (fetch_done) begin
            inst_next   = imem_rdata;
            pc_out_next = pc + PC_STEP;
            pc_next     = pc + PC_STEP;
            valid_next  = 1'b1;
        end

        case (state)
            S_FETCH: begin
                if (hold && at_boundary) begin
                    state_next = S_HOLD;
                    hlda_next  = 1'b1;
                end
            end
            S_HOLD: begin
                if (!hold) begin
                    state_next = S_FETCH;
                    hlda_next  = 1'b0;
                end
            end
            default: begin
                state_next = S_FETCH;
                hlda_next  = 1'b0;
            end
        endcase
    end

`ifdef FETCH_PERF_CNT_EN
    logic [CNT_W-1:0] fetch_cnt;
    logic [CNT_W-1:0] hold_cnt;

    // Discarded fetches (redirect in the same cycle) are not counted
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt <= '0;
            hold_cnt  <= '0;
        end else begin
            if (fetch_done && !branch_taken) begin
                fetch_cnt <= fetch_cnt + CNT_W'(1);
            end
            if (hlda) begin
                hold_cnt <= hold_cnt + CNT_W'(1);
            end
        end
    end

    assign perf_fetch_cnt = fetch_cnt;
    assign perf_hold_cnt  = hold_cnt;
`else
    assign perf_fetch_cnt = '0;
    assign perf_hold_cnt  = '0;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: vector table, directed corner sequences and
// randomized traffic against a cycle-level behavioural model.
module tb_if_fetch_unit;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic        hold;
    logic        hlda;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] inst_out;
    logic [31:0] pc_out;
    logic        flush;
    logic        valid;
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_hold_cnt;

    if_fetch_unit dut (
        .clk           (clk),
        .rst           (rst),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .imem_ready    (imem_ready),
        .hold          (hold),
        .hlda          (hlda),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .inst_out      (inst_out),
        .pc_out        (pc_out),
        .flush         (flush),
        .valid         (valid),
        .perf_fetch_cnt(perf_fetch_cnt),
        .perf_hold_cnt (perf_hold_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [31:0] m_pc, m_inst, m_pcout;
    logic        m_valid, m_flush, m_hold, m_known;
    logic [31:0] m_fcnt, m_hcnt;
    logic        seen_req;
    logic [31:0] seen_addr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, check bus side, advance model, check registered outputs
    task automatic step(input logic b, input logic [31:0] tgt, input logic h,
                        input logic s, input logic r, input logic rs);
        logic m_req, done;
        @(negedge clk);
        rst           = rs;
        branch_taken  = b;
        branch_target = tgt;
        hold          = h;
        stall         = s;
        imem_ready    = r;
        imem_rdata    = mem_word(imem_addr);
        #1;
        m_req     = m_known && !m_hold && !s && !rs;
        seen_req  = imem_req;
        seen_addr = imem_addr;
        if (m_known) begin
            chk("imem_req", {31'b0, imem_req}, {31'b0, m_req});
            chk("imem_addr", imem_addr, m_pc);
        end
        if (rs) begin
            m_pc = 32'h0; m_inst = 32'h0; m_pcout = 32'h0;
            m_valid = 1'b0; m_flush = 1'b0; m_hold = 1'b0;
            m_fcnt = 32'h0; m_hcnt = 32'h0; m_known = 1'b1;
        end else begin
            done = m_req && r;
            if (m_hold) m_hcnt = m_hcnt + 32'd1;
            if (b) begin
                m_pc    = {tgt[31:2], 2'b00};
                m_flush = 1'b1;
                m_valid = 1'b0;
            end else begin
                m_flush = 1'b0;
                m_valid = done;
                if (done) begin
                    m_inst  = mem_word(m_pc);
                    m_pcout = m_pc + 32'd4;
                    m_pc    = m_pc + 32'd4;
                    m_fcnt  = m_fcnt + 32'd1;
                end
            end
            if (!m_hold) m_hold = h && (done || !m_req);
            else         m_hold = h;
        end
        @(posedge clk);
        #1;
        if (m_known) begin
            chk("inst_out", inst_out, m_inst);
            chk("pc_out", pc_out, m_pcout);
            chk("valid", {31'b0, valid}, {31'b0, m_valid});
            chk("flush", {31'b0, flush}, {31'b0, m_flush});
            chk("hlda", {31'b0, hlda}, {31'b0, m_hold});
`ifdef FETCH_PERF_CNT_EN
            chk("perf_fetch_cnt", perf_fetch_cnt, m_fcnt);
            chk("perf_hold_cnt", perf_hold_cnt, m_hcnt);
`else
            chk("perf_fetch_cnt", perf_fetch_cnt, 32'h0);
            chk("perf_hold_cnt", perf_hold_cnt, 32'h0);
`endif
        end
    endtask

    typedef struct {
        logic        b;
        logic [31:0] tgt;
        logic        h;
        logic        s;
        logic        r;
        logic        ev;
        logic [31:0] epc;
        logic [31:0] einst;
        logic        ef;
        logic [31:0] eaddr;
    } vec_t;

    vec_t tbl[4];

    initial begin
        logic b, h, s, r, rs;
        logic [31:0] tgt;
        logic [31:0] exp_f, exp_h;

        m_known = 1'b0;
        m_pc = 32'h0; m_inst = 32'h0; m_pcout = 32'h0;
        m_valid = 1'b0; m_flush = 1'b0; m_hold = 1'b0;
        m_fcnt = 32'h0; m_hcnt = 32'h0;
        rst = 1'b1; branch_taken = 1'b0; branch_target = 32'h0;
        hold = 1'b0; stall = 1'b0; imem_ready = 1'b0; imem_rdata = 32'h0;

        // Sequential fetch from reset, then redirect colliding with the fetch of 8
        tbl[0] = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b1, 32'h4,   mem_word(32'h0),   1'b0, 32'h4};
        tbl[1] = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b1, 32'h8,   mem_word(32'h4),   1'b0, 32'h8};
        tbl[2] = '{1'b1, 32'h0000_0103, 1'b0, 1'b0, 1'b1, 1'b0, 32'h8,   mem_word(32'h4),   1'b1, 32'h100};
        tbl[3] = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b1, 32'h104, mem_word(32'h100), 1'b0, 32'h104};

        step(0, 0, 0, 0, 0, 1);
        chk("reset_valid", {31'b0, valid}, 32'h0);
        chk("reset_hlda", {31'b0, hlda}, 32'h0);
        chk("reset_pc_out", pc_out, 32'h0);
        chk("reset_imem_addr", imem_addr, 32'h0);
        chk("reset_req", {31'b0, imem_req}, 32'h0);

        for (int i = 0; i < 4; i++) begin
            step(tbl[i].b, tbl[i].tgt, tbl[i].h, tbl[i].s, tbl[i].r, 1'b0);
            chk("tbl_valid", {31'b0, valid}, {31'b0, tbl[i].ev});
            chk("tbl_pc_out", pc_out, tbl[i].epc);
            chk("tbl_inst", inst_out, tbl[i].einst);
            chk("tbl_flush", {31'b0, flush}, {31'b0, tbl[i].ef});
            chk("tbl_addr", imem_addr, tbl[i].eaddr);
        end

        // Hold raised while fetch of 0x10 is outstanding
        step(1, 32'h10, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 1, 0, 0, 0);
            chk("hold_wait_hlda", {31'b0, hlda}, 32'h0);
        end
        step(0, 0, 1, 0, 1, 0);
        chk("hold_grant_hlda", {31'b0, hlda}, 32'h1);
        chk("hold_grant_pc_out", pc_out, 32'h14);
        step(0, 0, 1, 0, 1, 0);
        chk("hold_req_idle", {31'b0, seen_req}, 32'h0);
        step(0, 0, 0, 0, 1, 0);
        chk("hold_release_hlda", {31'b0, hlda}, 32'h0);
        chk("hold_release_req", {31'b0, seen_req}, 32'h0);
        step(0, 0, 0, 0, 1, 0);
        chk("resume_req", {31'b0, seen_req}, 32'h1);
        chk("resume_addr", seen_addr, 32'h14);

        // Branch to 0x200 while in hold
        step(0, 0, 1, 0, 1, 0);
        chk("hold2_hlda", {31'b0, hlda}, 32'h1);
        step(1, 32'h200, 1, 0, 1, 0);
        chk("hold_branch_flush", {31'b0, flush}, 32'h1);
        step(0, 0, 1, 0, 1, 0);
        chk("hold_branch_flush_end", {31'b0, flush}, 32'h0);
        step(0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1, 0);
        chk("post_hold_addr", seen_addr, 32'h200);
        chk("post_hold_pc_out", pc_out, 32'h204);

        // Stall for 4 cycles at 0x20
        step(1, 32'h20, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 1, 1, 0);
            chk("stall_req", {31'b0, seen_req}, 32'h0);
            chk("stall_valid", {31'b0, valid}, 32'h0);
            chk("stall_pc_out", pc_out, 32'h204);
        end
        step(0, 0, 0, 0, 1, 0);
        chk("stall_resume_addr", seen_addr, 32'h20);
        chk("stall_resume_pc_out", pc_out, 32'h24);

        // PC wraps at 2^32
        step(1, 32'hFFFF_FFFE, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0);
        chk("wrap_pc_out", pc_out, 32'h0);
        chk("wrap_addr", imem_addr, 32'h0);

        // Perf: 10 fetches then a 5-cycle hold
        step(0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 1, 0);
        step(0, 0, 1, 1, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
`ifdef FETCH_PERF_CNT_EN
        exp_f = 32'd10; exp_h = 32'd5;
`else
        exp_f = 32'd0;  exp_h = 32'd0;
`endif
        chk("perf_fetch_10", perf_fetch_cnt, exp_f);
        chk("perf_hold_5", perf_hold_cnt, exp_h);

        // Randomized traffic against the model
        h = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            b   = ($urandom_range(0, 9) == 0);
            tgt = $urandom;
            if ($urandom_range(0, 7) == 0) h = ~h;
            s   = ($urandom_range(0, 5) == 0);
            r   = ($urandom_range(0, 3) != 0);
            rs  = ($urandom_range(0, 199) == 0);
            step(b, tgt, h, s, r, rs);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
